mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the Riscv151 pipeline.
- Arbitrates between the two requesters with round-robin priority.
- Registers the granted request and sequences it through issue and response.
- Routes the response back to its owner and exports per-side busy flags, which feed the pipeline's stall_i/stall_d.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_chk.sv | 24 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 25 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the main-memory arbiter between the I-cache and D-cache miss paths.
package mem_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_WAIT  = 2'd2;

   typedef logic owner_t;

   localparam owner_t OWNER_I = 1'b0;
   localparam owner_t OWNER_D = 1'b1;

   function automatic owner_t other_side(input owner_t side);
      return (side == OWNER_I) ? OWNER_D : OWNER_I;
   endfunction

endpackage

// File: rtl/mem_arbiter_chk.sv
// Requester-protocol and grant-exclusivity assertions for mem_arbiter.
module mem_arbiter_chk (
   input logic clk,
   input logic reset,
   input logic ic_req_valid,
   input logic ic_req_ready,
   input logic dc_req_valid,
   input logic dc_req_ready,
   input logic mem_req_valid
);

   ic_hold_a : assert property (@(posedge clk) disable iff (!reset)
      (ic_req_valid && !ic_req_ready) |=> ic_req_valid);

   dc_hold_a : assert property (@(posedge clk) disable iff (!reset)
      (dc_req_valid && !dc_req_ready) |=> dc_req_valid);

   one_grant_a : assert property (@(posedge clk)
      !(ic_req_ready && dc_req_ready));

   no_grant_in_service_a : assert property (@(posedge clk) disable iff (!reset)
      mem_req_valid |-> !(ic_req_ready || dc_req_ready));

endmodule

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a tie goes to the side that did not win last time.
import mem_arbiter_pkg::*;

module rr_arbiter2 (
   input  logic   req_i,
   input  logic   req_d,
   input  owner_t last_grant,
   output logic   gnt_valid,
   output owner_t gnt_owner
);

   // Winner selection
   always_comb begin
      gnt_valid = req_i | req_d;
      gnt_owner = OWNER_I;
      if (req_i && req_d) begin
         gnt_owner = other_side(last_grant);
      end else if (req_d) begin
         gnt_owner = OWNER_D;
      end else begin
         gnt_owner = OWNER_I;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the I-side and D-side miss paths,
// one outstanding transaction at a time.
import mem_arbiter_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter int MASK_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_req_ready,
   output logic              ic_resp_valid,
   output logic [DATA_W-1:0] ic_resp_data,
   output logic              ic_busy,
   input  logic              dc_req_valid,
   input  logic              dc_req_rnw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [DATA_W-1:0] dc_req_wdata,
   input  logic [MASK_W-1:0] dc_req_wmask,
   output logic              dc_req_ready,
   output logic              dc_resp_valid,
   output logic [DATA_W-1:0] dc_resp_data,
   output logic              dc_busy,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rnw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [MASK_W-1:0] mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data
);

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   owner_t            owner_r;
   owner_t            last_grant_r;
   logic              rnw_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [MASK_W-1:0] wmask_r;
   logic              gnt_valid_s;
   owner_t            gnt_owner_s;
   logic              grant_s;
   logic              accept_s;
   logic              resp_s;

   rr_arbiter2 u_rr (
      .req_i      (ic_req_valid),
      .req_d      (dc_req_valid),
      .last_grant (last_grant_r),
      .gnt_valid  (gnt_valid_s),
      .gnt_owner  (gnt_owner_s)
   );

   // Nothing is granted or completed while reset is held low.
   assign grant_s  = reset && (state_r == ARB_IDLE)  && gnt_valid_s;
   assign accept_s = reset && (state_r == ARB_ISSUE) && mem_req_ready;
   assign resp_s   = reset && (state_r == ARB_WAIT)  && mem_resp_valid;

   // Next-state sequencing: writes complete at accept, reads wait for data
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ARB_IDLE: begin
            if (grant_s) state_nxt_s = ARB_ISSUE;
            else         state_nxt_s = ARB_IDLE;
         end
         ARB_ISSUE: begin
            if (accept_s) state_nxt_s = rnw_r ? ARB_WAIT : ARB_IDLE;
            else          state_nxt_s = ARB_ISSUE;
         end
         ARB_WAIT: begin
            if (resp_s) state_nxt_s = ARB_IDLE;
            else        state_nxt_s = ARB_WAIT;
         end
         default: state_nxt_s = ARB_IDLE;
      endcase
   end

   // State, ownership and round-robin history
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ARB_IDLE;
         owner_r      <= OWNER_I;
         last_grant_r <= OWNER_I;
      end else begin
         state_r <= state_nxt_s;
         if (grant_s) begin
            owner_r      <= gnt_owner_s;
            last_grant_r <= gnt_owner_s;
         end else begin
            owner_r      <= owner_r;
            last_grant_r <= last_grant_r;
         end
      end
   end

   // Request latch; I-side requests are always full-line reads with no mask
   always_ff @(posedge clk) begin
      if (!reset) begin
         rnw_r   <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
         wmask_r <= '0;
      end else if (grant_s && (gnt_owner_s == OWNER_D)) begin
         rnw_r   <= dc_req_rnw;
         addr_r  <= dc_req_addr;
         wdata_r <= dc_req_wdata;
         wmask_r <= dc_req_wmask;
      end else if (grant_s) begin
         rnw_r   <= 1'b1;
         addr_r  <= ic_req_addr;
         wdata_r <= '0;
         wmask_r <= '0;
      end else begin
         rnw_r   <= rnw_r;
         addr_r  <= addr_r;
         wdata_r <= wdata_r;
         wmask_r <= wmask_r;
      end
   end

   assign ic_req_ready  = grant_s && (gnt_owner_s == OWNER_I);
   assign dc_req_ready  = grant_s && (gnt_owner_s == OWNER_D);

   assign mem_req_valid = (state_r == ARB_ISSUE);
   assign mem_req_rnw   = rnw_r;
   assign mem_req_addr  = addr_r;
   assign mem_req_wdata = wdata_r;
   assign mem_req_wmask = wmask_r;

   // Only the valids are steered; data fans out to both sides unconditionally.
   assign ic_resp_valid = resp_s && (owner_r == OWNER_I);
   assign dc_resp_valid = (resp_s && (owner_r == OWNER_D)) || (accept_s && !rnw_r);
   assign ic_resp_data  = mem_resp_data;
   assign dc_resp_data  = mem_resp_data;

   assign ic_busy = ic_req_valid || ((state_r != ARB_IDLE) && (owner_r == OWNER_I));
   assign dc_busy = dc_req_valid || ((state_r != ARB_IDLE) && (owner_r == OWNER_D));

   mem_arbiter_chk u_chk (
      .clk           (clk),
      .reset         (reset),
      .ic_req_valid  (ic_req_valid),
      .ic_req_ready  (ic_req_ready),
      .dc_req_valid  (dc_req_valid),
      .dc_req_ready  (dc_req_ready),
      .mem_req_valid (mem_req_valid)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory responder model plus a response scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;
   localparam int MASK_W = 16;

   logic              clk;
   logic              reset;
   logic              ic_req_valid;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_req_ready;
   logic              ic_resp_valid;
   logic [DATA_W-1:0] ic_resp_data;
   logic              ic_busy;
   logic              dc_req_valid;
   logic              dc_req_rnw;
   logic [ADDR_W-1:0] dc_req_addr;
   logic [DATA_W-1:0] dc_req_wdata;
   logic [MASK_W-1:0] dc_req_wmask;
   logic              dc_req_ready;
   logic              dc_resp_valid;
   logic [DATA_W-1:0] dc_resp_data;
   logic              dc_busy;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_rnw;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] mem_req_wdata;
   logic [MASK_W-1:0] mem_req_wmask;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_data;

   typedef struct {
      logic              is_write;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t ic_q[$];
   exp_t dc_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   ready_delay = 0;
   int   resp_lat = 1;
   int   stray_tok = 0;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_busy(ic_busy),
      .dc_req_valid(dc_req_valid), .dc_req_rnw(dc_req_rnw), .dc_req_addr(dc_req_addr),
      .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask), .dc_req_ready(dc_req_ready),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_busy(dc_busy),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: ready after ready_delay ISSUE cycles, read data resp_lat cycles after accept.
   initial begin : mem_model
      int   wait_cnt;
      int   resp_cnt;
      int   stray_seen;
      logic acc;
      logic acc_rnw;
      logic stray_now;
      wait_cnt = 0; resp_cnt = 0; stray_seen = 0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      forever begin
         @(negedge clk);
         acc       = mem_req_valid && mem_req_ready;
         acc_rnw   = mem_req_rnw;
         stray_now = (stray_tok != stray_seen);
         stray_seen = stray_tok;
         @(posedge clk); #1;
         mem_resp_valid = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) mem_resp_valid = 1'b1;
         end
         if (acc && acc_rnw) begin
            if (resp_lat <= 1) mem_resp_valid = 1'b1;
            else resp_cnt = resp_lat - 1;
         end
         if (stray_now) mem_resp_valid = 1'b1;
         if (acc) wait_cnt = 0;
         if (mem_req_valid) begin
            mem_req_ready = (wait_cnt >= ready_delay);
            wait_cnt++;
         end else begin
            mem_req_ready = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) tick();
      settle();
      checks++; if ({ic_req_ready, dc_req_ready, mem_req_valid, ic_resp_valid, dc_resp_valid, ic_busy, dc_busy} !== 7'b0) begin errors++; $display("FAIL reset_outputs: got %b, expected 0000000", {ic_req_ready, dc_req_ready, mem_req_valid, ic_resp_valid, dc_resp_valid, ic_busy, dc_busy}); end
      checks++; if ({mem_req_rnw, mem_req_addr, mem_req_wmask} !== {1'b0, 28'h0, 16'h0}) begin errors++; $display("FAIL reset_fields: got rnw=%b addr=%h mask=%h, expected all zero", mem_req_rnw, mem_req_addr, mem_req_wmask); end
      tick();
      reset = 1'b1;
   endtask

   task automatic test_ic_read();
      mem_data = {16{8'hA5}};
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000100;
      settle();
      checks++; if ({ic_req_ready, dc_req_ready, mem_req_valid} !== 3'b100) begin errors++; $display("FAIL ic_rd_accept: got ready_i/ready_d/mem_valid=%b, expected 100", {ic_req_ready, dc_req_ready, mem_req_valid}); end
      ic_q.push_back('{1'b0, {16{8'hA5}}});
      tick();
      ic_req_valid = 1'b0;
      settle();
      checks++; if ({mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wmask} !== {1'b1, 1'b1, 28'h0000100, 16'h0}) begin errors++; $display("FAIL ic_rd_issue: got valid=%b rnw=%b addr=%h mask=%h, expected 1 1 0000100 0000", mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wmask); end
      tick();
      settle();
      checks++; if ({ic_resp_valid, dc_resp_valid} !== 2'b10 || ic_resp_data !== {16{8'hA5}}) begin errors++; $display("FAIL ic_rd_resp: got valid_i/valid_d=%b data=%h, expected 10 with a5..a5", {ic_resp_valid, dc_resp_valid}, ic_resp_data); end
      tick();
      settle();
      checks++; if ({ic_busy, mem_req_valid} !== 2'b00) begin errors++; $display("FAIL ic_rd_idle: got busy/mem_valid=%b, expected 00", {ic_busy, mem_req_valid}); end
      tick();
   endtask

   task automatic test_dc_write();
      ready_delay = 3;
      dc_req_valid = 1'b1; dc_req_rnw = 1'b0; dc_req_addr = 28'h0000200;
      dc_req_wdata = {4{32'hDEADBEEF}}; dc_req_wmask = 16'h000F;
      settle();
      checks++; if (dc_req_ready !== 1'b1) begin errors++; $display("FAIL dc_wr_accept: got %b, expected 1", dc_req_ready); end
      dc_q.push_back('{1'b1, '0});
      tick();
      dc_req_valid = 1'b0; dc_req_addr = 28'hFFFFFFF; dc_req_wdata = '0; dc_req_wmask = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         settle();
         checks++; if ({mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wdata, mem_req_wmask} !== {1'b1, 1'b0, 28'h0000200, {4{32'hDEADBEEF}}, 16'h000F}) begin errors++; $display("FAIL dc_wr_stable[%0d]: got valid=%b rnw=%b addr=%h mask=%h wdata=%h", k, mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_wmask, mem_req_wdata); end
         checks++; if ({dc_resp_valid, dc_busy} !== {(k == 3), 1'b1}) begin errors++; $display("FAIL dc_wr_resp[%0d]: got resp/busy=%b, expected %b1", k, {dc_resp_valid, dc_busy}, (k == 3)); end
         tick();
      end
      settle();
      checks++; if ({dc_busy, mem_req_valid, dc_resp_valid} !== 3'b000) begin errors++; $display("FAIL dc_wr_done: got busy/mem_valid/resp=%b, expected 000", {dc_busy, mem_req_valid, dc_resp_valid}); end
      tick();
      ready_delay = 0;
   endtask

   task automatic test_tie();
      logic found;
      logic side_d;
      logic [DATA_W-1:0] d;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000300;
      dc_req_valid = 1'b1; dc_req_rnw = 1'b1; dc_req_addr = 28'h0000400;
      dc_req_wdata = '0; dc_req_wmask = '0;
      for (int g = 0; g < 5; g++) begin
         found = 1'b0;
         for (int c = 0; c < 20 && !found; c++) begin
            settle();
            if (ic_req_ready || dc_req_ready) found = 1'b1;
            else tick();
         end
         checks++;
         if (!found) begin
            errors++; $display("FAIL tie_grant[%0d]: got no grant within 20 cycles, expected a grant", g);
         end else begin
            side_d = dc_req_ready;
            if ({ic_req_ready, dc_req_ready} !== {(g % 2 != 0), (g % 2 == 0)}) begin errors++; $display("FAIL tie_grant[%0d]: got ready_i/ready_d=%b%b, expected %b%b", g, ic_req_ready, dc_req_ready, (g % 2 != 0), (g % 2 == 0)); end
            d = {4{32'h70000000 + 32'(g)}};
            mem_data = d;
            if (side_d) dc_q.push_back('{1'b0, d});
            else ic_q.push_back('{1'b0, d});
            tick();
            if (side_d) begin
               if (g < 4) dc_req_addr = dc_req_addr + 28'h10;
               else dc_req_valid = 1'b0;
            end else begin
               if (g < 3) ic_req_addr = ic_req_addr + 28'h10;
               else ic_req_valid = 1'b0;
            end
         end
      end
      ic_req_valid = 1'b0; dc_req_valid = 1'b0;
      for (int c = 0; c < 20 && (ic_q.size() + dc_q.size()) > 0; c++) tick();
      checks++; if ((ic_q.size() + dc_q.size()) != 0) begin errors++; $display("FAIL tie_drain: got %0d responses outstanding, expected 0", ic_q.size() + dc_q.size()); end
      tick();
   endtask

   task automatic test_stray();
      logic found;
      stray_tok++;
      tick();
      settle();
      checks++; if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin errors++; $display("FAIL stray_idle: got resp_i/resp_d=%b, expected 00", {ic_resp_valid, dc_resp_valid}); end
      tick();
      ready_delay = 2;
      mem_data = {4{32'h5A5A0001}};
      dc_req_valid = 1'b1; dc_req_rnw = 1'b1; dc_req_addr = 28'h0000500;
      stray_tok++;
      settle();
      checks++; if (dc_req_ready !== 1'b1) begin errors++; $display("FAIL stray_dc_accept: got %b, expected 1", dc_req_ready); end
      dc_q.push_back('{1'b0, {4{32'h5A5A0001}}});
      tick();
      dc_req_valid = 1'b0;
      settle();
      checks++; if ({mem_req_valid, ic_resp_valid, dc_resp_valid} !== 3'b100) begin errors++; $display("FAIL stray_issue: got mem_valid/resp_i/resp_d=%b, expected 100", {mem_req_valid, ic_resp_valid, dc_resp_valid}); end
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         tick();
         settle();
         if (dc_resp_valid) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL stray_real_resp: got no dc response within 20 cycles, expected one"); end
      tick();
      checks++; if (dc_q.size() != 0) begin errors++; $display("FAIL stray_drain: got %0d outstanding, expected 0", dc_q.size()); end
      ready_delay = 0;
   endtask

   task automatic test_reset_wait();
      resp_lat = 3;
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000600;
      settle();
      checks++; if (ic_req_ready !== 1'b1) begin errors++; $display("FAIL rstw_accept: got %b, expected 1", ic_req_ready); end
      tick();
      ic_req_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      settle();
      checks++; if ({mem_req_valid, ic_busy, dc_busy, ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready} !== 7'b0) begin errors++; $display("FAIL rstw_outputs: got %b, expected 0000000", {mem_req_valid, ic_busy, dc_busy, ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready}); end
      tick();
      settle();
      checks++; if ({mem_resp_valid, ic_resp_valid} !== 2'b10) begin errors++; $display("FAIL rstw_late_resp: got mem_resp/ic_resp=%b, expected 10", {mem_resp_valid, ic_resp_valid}); end
      tick();
      resp_lat = 1;
   endtask

   task automatic test_back_to_back();
      logic seen;
      resp_lat = 5;
      mem_data = {4{32'hBEEF0007}};
      dc_req_valid = 1'b1; dc_req_rnw = 1'b1; dc_req_addr = 28'h0000700;
      settle();
      checks++; if (dc_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_dc_accept: got %b, expected 1", dc_req_ready); end
      dc_q.push_back('{1'b0, {4{32'hBEEF0007}}});
      tick();
      dc_req_valid = 1'b0;
      ic_req_valid = 1'b1; ic_req_addr = 28'h0000800;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         settle();
         checks++; if ({ic_busy, ic_req_ready} !== 2'b10) begin errors++; $display("FAIL b2b_ic_busy[%0d]: got busy/ready=%b, expected 10", c, {ic_busy, ic_req_ready}); end
         if (dc_resp_valid) seen = 1'b1;
         else tick();
      end
      checks++; if (!seen) begin errors++; $display("FAIL b2b_dc_resp: got no dc response within 20 cycles, expected one"); end
      tick();
      settle();
      checks++; if (ic_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ic_grant: got %b, expected 1", ic_req_ready); end
      mem_data = {4{32'h1CE00008}};
      ic_q.push_back('{1'b0, {4{32'h1CE00008}}});
      tick();
      ic_req_valid = 1'b0;
      for (int c = 0; c < 20 && (ic_q.size() + dc_q.size()) > 0; c++) tick();
      checks++; if ((ic_q.size() + dc_q.size()) != 0) begin errors++; $display("FAIL b2b_drain: got %0d outstanding, expected 0", ic_q.size() + dc_q.size()); end
      resp_lat = 1;
   endtask

   initial begin
      reset = 1'b0;
      ic_req_valid = 1'b0; ic_req_addr = '0;
      dc_req_valid = 1'b0; dc_req_rnw = 1'b1; dc_req_addr = '0;
      dc_req_wdata = '0; dc_req_wmask = '0;
      mem_data = '0;
      fork
         forever begin
            @(negedge clk);
            if (ic_resp_valid === 1'b1) begin
               checks++;
               if (ic_q.size() == 0) begin
                  errors++; $display("FAIL ic_resp_unexpected: got response data %h, expected no response", ic_resp_data);
               end else begin
                  mon_e = ic_q.pop_front();
                  if (ic_resp_data !== mon_e.data) begin errors++; $display("FAIL ic_resp_data: got %h, expected %h", ic_resp_data, mon_e.data); end
               end
            end
            if (dc_resp_valid === 1'b1) begin
               checks++;
               if (dc_q.size() == 0) begin
                  errors++; $display("FAIL dc_resp_unexpected: got response data %h, expected no response", dc_resp_data);
               end else begin
                  mon_e = dc_q.pop_front();
                  if (!mon_e.is_write && dc_resp_data !== mon_e.data) begin errors++; $display("FAIL dc_resp_data: got %h, expected %h", dc_resp_data, mon_e.data); end
               end
            end
         end
      join_none
      test_reset();
      test_ic_read();
      test_dc_write();
      test_tie();
      test_stray();
      test_reset_wait();
      test_back_to_back();
      repeat (3) tick();
      checks++; if ((ic_q.size() + dc_q.size()) != 0) begin errors++; $display("FAIL final_drain: got %0d outstanding, expected 0", ic_q.size() + dc_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
